// File: rtl/ascon_pin_ctrl.sv
// Pin-level sequencer: serially loads key, nonce and one data block from pads,
// launches one Ascon core operation, then shifts result block and tag out.
module ascon_pin_ctrl #(
  parameter int KEY_W   = 128,
  parameter int NONCE_W = 128,
  parameter int BLK_W   = 64,
  parameter int TAG_W   = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pin_sdi,
  input  logic               pin_stb,
  input  logic [1:0]         pin_sel,
  input  logic               pin_go,
  input  logic               pin_dec,
  output logic               pin_sdo,
  output logic               pin_vld,
  output logic               pin_busy,
  output logic [10:0]        pin_oeb,
  output logic [KEY_W-1:0]   core_key,
  output logic [NONCE_W-1:0] core_nonce,
  output logic [BLK_W-1:0]   core_din,
  output logic               core_dec,
  output logic               core_start,
  input  logic               core_done,
  input  logic [BLK_W-1:0]   core_dout,
  input  logic [TAG_W-1:0]   core_tag
);

  localparam int         RES_W    = BLK_W + TAG_W;
  localparam int         PAD_W    = 6;
  localparam logic [7:0] LAST_BIT = 8'(RES_W - 1);

  localparam logic [1:0] SEL_KEY   = 2'b00;
  localparam logic [1:0] SEL_NONCE = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHIFT = 2'd3
  } state_e;

  // Pad synchronizer: bit order {dec, go, sel[1:0], stb, sdi}
  logic [PAD_W-1:0] pad_raw;
  logic [PAD_W-1:0] sync1_q;
  logic [PAD_W-1:0] sync2_q;
  logic             stb_dly_q;
  logic             go_dly_q;

  logic       sdi_sync;
  logic       stb_sync;
  logic [1:0] sel_sync;
  logic       go_sync;
  logic       dec_sync;
  logic       stb_edge;
  logic       go_edge;

  assign pad_raw = {pin_dec, pin_go, pin_sel, pin_stb, pin_sdi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stb_dly_q <= 1'b0;
      go_dly_q  <= 1'b0;
    end else begin
      sync1_q   <= pad_raw;
      sync2_q   <= sync1_q;
      stb_dly_q <= sync2_q[1];
      go_dly_q  <= sync2_q[4];
    end
  end

  assign sdi_sync = sync2_q[0];
  assign stb_sync = sync2_q[1];
  assign sel_sync = sync2_q[3:2];
  assign go_sync  = sync2_q[4];
  assign dec_sync = sync2_q[5];
  assign stb_edge = stb_sync & ~stb_dly_q;
  assign go_edge  = go_sync & ~go_dly_q;

  // Sequencer state and datapath registers
  state_e             state_q;
  logic [KEY_W-1:0]   key_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [BLK_W-1:0]   din_q;
  logic               dec_q;
  logic               start_q;
  logic               busy_q;
  logic               vld_q;
  logic [RES_W-1:0]   out_sr_q;
  logic [7:0]         cnt_q;

  logic [KEY_W-1:0]   key_d;
  logic [NONCE_W-1:0] nonce_d;
  logic [BLK_W-1:0]   din_d;

  // Shift-in candidates; only committed on a strobe edge in IDLE
  always_comb begin
    key_d   = {key_q[KEY_W-2:0], sdi_sync};
    nonce_d = {nonce_q[NONCE_W-2:0], sdi_sync};
    din_d   = {din_q[BLK_W-2:0], sdi_sync};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      key_q    <= '0;
      nonce_q  <= '0;
      din_q    <= '0;
      dec_q    <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
      out_sr_q <= '0;
      cnt_q    <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (stb_edge) begin
            case (sel_sync)
              SEL_KEY:   key_q   <= key_d;
              SEL_NONCE: nonce_q <= nonce_d;
              SEL_DATA:  din_q   <= din_d;
              default:   ;
            endcase
          end
          // A simultaneous strobe still lands, so the core sees the shifted value
          if (go_edge) begin
            dec_q   <= dec_sync;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            out_sr_q <= {core_dout, core_tag};
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            vld_q    <= 1'b1;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (stb_edge) begin
            out_sr_q <= {out_sr_q[RES_W-2:0], 1'b0};
            cnt_q    <= cnt_q + 8'd1;
            if (cnt_q == LAST_BIT) begin
              vld_q   <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pin_sdo    = out_sr_q[RES_W-1];
  assign pin_vld    = vld_q;
  assign pin_busy   = busy_q;
  assign pin_oeb    = 11'b000_1111_1111;
  assign core_key   = key_q;
  assign core_nonce = nonce_q;
  assign core_din   = din_q;
  assign core_dec   = dec_q;
  assign core_start = start_q;

endmodule

// File: tb/tb_ascon_pin_ctrl.sv
// Scoreboard bench for ascon_pin_ctrl: directed pad sequences push expected
// snapshots, launches and readout bits; monitors pop and compare.
module tb_ascon_pin_ctrl;

  localparam logic [127:0] KEY1  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KEY2  = 128'h00102030405060708090A0B0C0D0E0FB;
  localparam logic [127:0] NONCE = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [63:0]  DATA  = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0]  DOUT  = 64'h0123456789ABCDEF;
  localparam logic [127:0] TAG   = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pin_sdi, pin_stb, pin_go, pin_dec;
  logic [1:0]   pin_sel;
  logic         pin_sdo, pin_vld, pin_busy;
  logic [10:0]  pin_oeb;
  logic [127:0] core_key, core_nonce;
  logic [63:0]  core_din;
  logic         core_dec, core_start, core_done;
  logic [63:0]  core_dout;
  logic [127:0] core_tag;

  ascon_pin_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pin_sdi(pin_sdi), .pin_stb(pin_stb), .pin_sel(pin_sel),
    .pin_go(pin_go), .pin_dec(pin_dec),
    .pin_sdo(pin_sdo), .pin_vld(pin_vld), .pin_busy(pin_busy), .pin_oeb(pin_oeb),
    .core_key(core_key), .core_nonce(core_nonce), .core_din(core_din),
    .core_dec(core_dec), .core_start(core_start), .core_done(core_done),
    .core_dout(core_dout), .core_tag(core_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] nonce;
    logic [63:0]  din;
    logic         dec;
    logic         vld;
    logic         busy;
    logic         sdo;
  } snap_t;

  typedef struct {
    logic [127:0] key;
    logic [127:0] nonce;
    logic [63:0]  din;
    logic         dec;
    int           cyc;
  } launch_t;

  snap_t   snap_q[$];
  launch_t launch_q[$];
  logic    bit_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_start  = 0;
  int bit_idx  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: static snapshots and launch pulses, sampled on the falling edge
  always @(negedge clk) begin
    while (snap_q.size() > 0) begin
      snap_t s;
      s = snap_q.pop_front();
      chk({s.name, ".key"},   core_key,   s.key);
      chk({s.name, ".nonce"}, core_nonce, s.nonce);
      chk({s.name, ".din"},   {64'd0, core_din}, {64'd0, s.din});
      chk({s.name, ".dec"},   {127'd0, core_dec}, {127'd0, s.dec});
      chk({s.name, ".vld"},   {127'd0, pin_vld},  {127'd0, s.vld});
      chk({s.name, ".busy"},  {127'd0, pin_busy}, {127'd0, s.busy});
      chk({s.name, ".sdo"},   {127'd0, pin_sdo},  {127'd0, s.sdo});
      chk({s.name, ".start"}, {127'd0, core_start}, 128'd0);
      chk({s.name, ".oeb"},   {117'd0, pin_oeb}, {117'd0, 11'b000_1111_1111});
      $display("snapshot %s checked at cycle %0d", s.name, cyc);
    end
    if (core_start === 1'b1) begin
      n_start++;
      if (launch_q.size() == 0) begin
        chk("unexpected_start", {96'd0, 32'(cyc)}, 128'd0);
      end else begin
        launch_t l;
        l = launch_q.pop_front();
        chk("launch.key",   core_key,   l.key);
        chk("launch.nonce", core_nonce, l.nonce);
        chk("launch.din",   {64'd0, core_din}, {64'd0, l.din});
        chk("launch.dec",   {127'd0, core_dec}, {127'd0, l.dec});
        chk("launch.cycle", {96'd0, 32'(cyc)}, {96'd0, 32'(l.cyc)});
        $display("launch seen at cycle %0d din=%h dec=%0b", cyc, core_din, core_dec);
      end
    end
  end

  // Monitor: the host samples sdo just before each strobe rise in readout
  always @(posedge pin_stb) begin
    if (pin_vld === 1'b1) begin
      if (bit_q.size() == 0) begin
        chk("unexpected_readout_bit", {127'd0, pin_sdo}, 128'd0);
      end else begin
        chk($sformatf("sdo_bit%0d", bit_idx), {127'd0, pin_sdo}, {127'd0, bit_q.pop_front()});
        bit_idx++;
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap(input string nm, input logic [127:0] k, input logic [127:0] n,
                      input logic [63:0] d, input logic dc, input logic v,
                      input logic b, input logic so);
    snap_t s;
    s.name = nm; s.key = k; s.nonce = n; s.din = d;
    s.dec = dc; s.vld = v; s.busy = b; s.sdo = so;
    @(posedge clk); #1;
    snap_q.push_back(s);
    wait_neg(2);
  endtask

  task automatic strobe();
    @(negedge clk);
    pin_stb = 1'b1;
    wait_neg(3);
    pin_stb = 1'b0;
    wait_neg(3);
  endtask

  task automatic shift_in(input logic [1:0] sel, input logic b);
    @(negedge clk);
    pin_sel = sel;
    pin_sdi = b;
    strobe();
  endtask

  task automatic shift_word(input logic [1:0] sel, input logic [127:0] val, input int w);
    for (int i = w - 1; i >= 0; i--) shift_in(sel, val[i]);
  endtask

  task automatic launch(input logic [127:0] k, input logic [127:0] n,
                        input logic [63:0] d, input logic dc);
    launch_t l;
    l.key = k; l.nonce = n; l.din = d; l.dec = dc;
    @(negedge clk);
    l.cyc = cyc + 3;
    launch_q.push_back(l);
    pin_go = 1'b1;
    wait_neg(4);
    pin_go = 1'b0;
    wait_neg(4);
  endtask

  task automatic done_pulse(input logic [63:0] d, input logic [127:0] t);
    @(negedge clk);
    core_done = 1'b1;
    core_dout = d;
    core_tag  = t;
    @(negedge clk);
    core_done = 1'b0;
    core_dout = '0;
    core_tag  = '0;
  endtask

  initial begin
    logic [191:0] res;
    res = {DOUT, TAG};
    rst_n = 1'b0;
    pin_sdi = 0; pin_stb = 0; pin_go = 0; pin_dec = 0; pin_sel = 2'b11;
    core_done = 0; core_dout = '0; core_tag = '0;
    wait_neg(4);
    snap("reset", '0, '0, '0, 0, 0, 0, 0);
    rst_n = 1'b1;
    wait_neg(2);

    // Load key, nonce, data, then four extra key bits 1011
    shift_word(2'b00, KEY1, 128);
    shift_word(2'b01, NONCE, 128);
    shift_word(2'b10, {64'd0, DATA}, 64);
    snap("loaded", KEY1, NONCE, DATA, 0, 0, 0, 0);
    shift_word(2'b00, 128'hB, 4);
    snap("key_extra", KEY2, NONCE, DATA, 0, 0, 0, 0);

    // Ignored: sel=11 strobes, core_done in IDLE
    shift_word(2'b11, 128'h15, 5);
    snap("sel11", KEY2, NONCE, DATA, 0, 0, 0, 0);
    done_pulse(DOUT, TAG);
    wait_neg(3);
    snap("done_idle", KEY2, NONCE, DATA, 0, 0, 0, 0);

    // Launch in decrypt mode
    pin_dec = 1'b1;
    pin_sel = 2'b00;
    wait_neg(4);
    launch(KEY2, NONCE, DATA, 1'b1);
    snap("wait", KEY2, NONCE, DATA, 1, 0, 1, 0);

    // Second go and strobes while waiting must do nothing
    @(negedge clk); pin_go = 1'b1;
    wait_neg(5);
    pin_go = 1'b0;
    shift_word(2'b00, 128'h7, 3);
    snap("wait_ignored", KEY2, NONCE, DATA, 1, 0, 1, 0);

    // Readout of 192 bits
    done_pulse(DOUT, TAG);
    wait_neg(3);
    snap("shift_start", KEY2, NONCE, DATA, 1, 1, 0, DOUT[63]);
    pin_sel = 2'b11;
    bit_idx = 0;
    for (int i = 191; i >= 0; i--) bit_q.push_back(res[i]);
    for (int i = 0; i < 192; i++) strobe();
    wait_neg(4);
    snap("readout_done", KEY2, NONCE, DATA, 1, 0, 0, 0);

    // Second operation, reset after 50 bits out
    pin_dec = 1'b0;
    wait_neg(4);
    launch(KEY2, NONCE, DATA, 1'b0);
    done_pulse(DOUT, TAG);
    wait_neg(3);
    bit_idx = 0;
    for (int i = 191; i >= 142; i--) bit_q.push_back(res[i]);
    for (int i = 0; i < 50; i++) strobe();
    @(negedge clk); rst_n = 1'b0;
    snap("mid_reset", '0, '0, '0, 0, 0, 0, 0);
    rst_n = 1'b1;
    wait_neg(3);
    done_pulse(DOUT, TAG);
    wait_neg(3);
    snap("done_after_reset", '0, '0, '0, 0, 0, 0, 0);

    // Simultaneous strobe and go with sel=10, sdi=1
    pin_dec = 1'b1;
    pin_sel = 2'b10;
    pin_sdi = 1'b1;
    wait_neg(4);
    begin
      launch_t l;
      l.key = '0; l.nonce = '0; l.din = 64'h1; l.dec = 1'b1;
      l.cyc = cyc + 3;
      launch_q.push_back(l);
      pin_stb = 1'b1;
      pin_go  = 1'b1;
      wait_neg(4);
      pin_stb = 1'b0;
      pin_go  = 1'b0;
      wait_neg(4);
    end
    snap("simul", '0, '0, 64'h1, 1, 0, 1, 0);

    wait_neg(4);
    chk("start_count", {96'd0, 32'(n_start)}, 128'd3);
    chk("launch_q_empty", {96'd0, 32'(launch_q.size())}, 128'd0);
    chk("bit_q_empty", {96'd0, 32'(bit_q.size())}, 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
